// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: command front-end for the ALU.
// Buffers operand/opcode commands in a DEPTH-entry FIFO, issues them one at
// a time to the ALU, waits out its one-cycle registered latency and captures
// the result and flags into a valid/ready response register.
// Divide-by-zero results are forced to zero and flagged with rsp_err.
// Optional build macro: ALU_SEQ_STATS_EN adds rsp_count and err_count outputs.

module alu_op_sequencer #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [WIDTH-1:0]   cmd_a,
    input  logic [WIDTH-1:0]   cmd_b,
    input  logic [2:0]         cmd_op,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [2:0]         alu_select,
    input  logic [WIDTH*2-1:0] alu_out,
    input  logic               alu_carry_out,
    input  logic               alu_a_greater,
    input  logic               alu_a_equal,
    input  logic               alu_a_less,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH*2-1:0] rsp_result,
    output logic [2:0]         rsp_flags,
    output logic               rsp_carry,
    output logic               rsp_err,
`ifdef ALU_SEQ_STATS_EN
    output logic [15:0]        rsp_count,
    output logic [7:0]         err_count,
`endif
    output logic               busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = 2 * WIDTH + 3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t state;
    state_t next_state;

    logic [EW-1:0]    fifo_mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             capture;
    logic             rsp_done;
    logic             div_zero;
    logic [WIDTH-1:0] head_a;
    logic [WIDTH-1:0] head_b;
    logic [2:0]       head_op;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign busy      = (state != IDLE) || !empty;
    assign div_zero  = (alu_select == 3'b111) && (alu_b == '0);

    assign {head_a, head_b, head_op} = fifo_mem[rd_ptr];

    // FIFO storage; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_a, cmd_b, cmd_op};
        end
    end

    // FIFO pointers and occupancy; push and pop together leave count unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic plus the pop/capture/handshake strobes
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        capture    = 1'b0;
        rsp_done   = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                next_state = WAIT;
            end
            WAIT: begin
                capture    = 1'b1;
                next_state = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_done = 1'b1;
                    if (!empty) begin
                        pop        = 1'b1;
                        next_state = ISSUE;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // ALU operand registers change only when a command is popped
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_select <= '0;
        end else if (pop) begin
            alu_a      <= head_a;
            alu_b      <= head_b;
            alu_select <= head_op;
        end
    end

    // Response register: capture in WAIT, hold until the consumer accepts
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_carry  <= 1'b0;
            rsp_err    <= 1'b0;
        end else if (capture) begin
            rsp_valid  <= 1'b1;
            rsp_result <= div_zero ? '0 : alu_out;
            rsp_err    <= div_zero;
            rsp_flags  <= {alu_a_greater, alu_a_equal, alu_a_less};
            rsp_carry  <= alu_carry_out;
        end else if (rsp_done) begin
            rsp_valid  <= 1'b0;
        end
    end

`ifdef ALU_SEQ_STATS_EN
    // Saturating counters of completed handshakes and of errored ones
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_count <= '0;
            err_count <= '0;
        end else if (rsp_done) begin
            if (rsp_count != 16'hFFFF) begin
                rsp_count <= rsp_count + 16'd1;
            end
            if (rsp_err && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer (WIDTH=4, DEPTH=4).
// Includes a behavioural ALU stand-in and a response reference model.
// Stats checks are compiled only when ALU_SEQ_STATS_EN is defined.

module tb_alu_op_sequencer;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [7:0] result;
        logic [2:0] flags;
        logic       carry;
        logic       err;
    } rsp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [2:0] cmd_op;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_select;
    logic [7:0] alu_out;
    logic       alu_carry_out;
    logic       alu_a_greater;
    logic       alu_a_equal;
    logic       alu_a_less;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic [2:0] rsp_flags;
    logic       rsp_carry;
    logic       rsp_err;
    logic       busy;
`ifdef ALU_SEQ_STATS_EN
    logic [15:0] rsp_count;
    logic [7:0]  err_count;
`endif

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    rsp_t exp_q[$];
    rsp_t last_rsp;

    alu_op_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_a         (cmd_a),
        .cmd_b         (cmd_b),
        .cmd_op        (cmd_op),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_select    (alu_select),
        .alu_out       (alu_out),
        .alu_carry_out (alu_carry_out),
        .alu_a_greater (alu_a_greater),
        .alu_a_equal   (alu_a_equal),
        .alu_a_less    (alu_a_less),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_result    (rsp_result),
        .rsp_flags     (rsp_flags),
        .rsp_carry     (rsp_carry),
        .rsp_err       (rsp_err),
`ifdef ALU_SEQ_STATS_EN
        .rsp_count     (rsp_count),
        .err_count     (err_count),
`endif
        .busy          (busy)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // ALU arithmetic; divide by zero yields a deliberately bogus value
    function automatic logic [7:0] alu_func(input logic [3:0] a, input logic [3:0] b,
                                            input logic [2:0] op);
        logic [7:0] ea;
        logic [7:0] eb;
        ea = {4'b0, a};
        eb = {4'b0, b};
        case (op)
            3'd0:    return ea + eb;
            3'd1:    return ea - eb;
            3'd2:    return ea & eb;
            3'd3:    return ea | eb;
            3'd4:    return ea ^ eb;
            3'd5:    return {7'b0, (a == b)};
            3'd6:    return ea * eb;
            default: return (b == 4'd0) ? 8'hEE : (ea / eb);
        endcase
    endfunction

    // Expected response of one command
    function automatic rsp_t ref_model(input logic [3:0] a, input logic [3:0] b,
                                       input logic [2:0] op);
        rsp_t       r;
        logic [4:0] s;
        s        = {1'b0, a} + {1'b0, b};
        r.err    = (op == 3'd7) && (b == 4'd0);
        r.result = r.err ? 8'h00 : alu_func(a, b, op);
        r.flags  = {(a > b), (a == b), (a < b)};
        r.carry  = s[4];
        return r;
    endfunction

    function automatic rsp_t grab();
        return {rsp_result, rsp_flags, rsp_carry, rsp_err};
    endfunction

    // ALU stand-in: registered result, combinational flags and carry
    always @(posedge clk) alu_out <= alu_func(alu_a, alu_b, alu_select);
    assign alu_carry_out = (({1'b0, alu_a} + {1'b0, alu_b}) > 5'd15);
    assign alu_a_greater = (alu_a > alu_b);
    assign alu_a_equal   = (alu_a == alu_b);
    assign alu_a_less    = (alu_a < alu_b);

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        cmd_a = '0;
        cmd_b = '0;
        cmd_op = '0;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_rsp_valid: got %b want 0", rsp_valid);
        end
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_cmd_ready: got %b want 1", cmd_ready);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_busy: got %b want 0", busy);
        end
        total++;
        if ({alu_a, alu_b, alu_select} !== 11'b0) begin
            bad++;
            $display("[TB] FAIL reset_alu_regs: got %h want 0", {alu_a, alu_b, alu_select});
        end
        total++;
        if (grab() !== 13'b0) begin
            bad++;
            $display("[TB] FAIL reset_rsp_regs: got %h want 0", grab());
        end
    endtask

    // One command into an idle block: checks latency, fields and return to idle
    task automatic run_single(input logic [3:0] a, input logic [3:0] b,
                              input logic [2:0] op, input string name);
        rsp_t e;
        int   lat = 1;
        bit   seen = 0;
        e = ref_model(a, b, op);
        cmd_a = a;
        cmd_b = b;
        cmd_op = op;
        cmd_valid = 1'b1;
        rsp_ready = 1'b1;
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL %s_cmd_ready: got %b want 1", name, cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
        while (lat <= 10 && !seen) begin
            if (rsp_valid === 1'b1) begin
                seen = 1;
            end else begin
                tick();
                lat++;
            end
        end
        total++;
        if (!seen || lat != 4) begin
            bad++;
            $display("[TB] FAIL %s_latency: got %0d want 4 (seen=%0d)", name, lat, seen);
        end
        if (seen) begin
            last_rsp = grab();
            total++;
            if (rsp_result !== e.result) begin
                bad++;
                $display("[TB] FAIL %s_result: got %h want %h", name, rsp_result, e.result);
            end
            total++;
            if (rsp_flags !== e.flags) begin
                bad++;
                $display("[TB] FAIL %s_flags: got %b want %b", name, rsp_flags, e.flags);
            end
            total++;
            if (rsp_carry !== e.carry) begin
                bad++;
                $display("[TB] FAIL %s_carry: got %b want %b", name, rsp_carry, e.carry);
            end
            total++;
            if (rsp_err !== e.err) begin
                bad++;
                $display("[TB] FAIL %s_err: got %b want %b", name, rsp_err, e.err);
            end
            tick();
        end
        total++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s_idle_after: got valid=%b busy=%b want 0 0",
                     name, rsp_valid, busy);
        end
    endtask

    task automatic test_add();
        run_single(4'd9, 4'd8, 3'd0, "add");
        total++;
        if (last_rsp.result !== 8'h11 || last_rsp.carry !== 1'b1 || last_rsp.flags !== 3'b100) begin
            bad++;
            $display("[TB] FAIL add_const: got res=%h c=%b f=%b want 11 1 100",
                     last_rsp.result, last_rsp.carry, last_rsp.flags);
        end
        run_single(4'd3, 4'd9, 3'd1, "sub");
        run_single(4'd5, 4'd5, 3'd5, "eq");
    endtask

    task automatic test_div_zero();
        run_single(4'd7, 4'd0, 3'd7, "div0");
        total++;
        if (last_rsp.result !== 8'h00 || last_rsp.err !== 1'b1 || last_rsp.flags !== 3'b100) begin
            bad++;
            $display("[TB] FAIL div0_const: got res=%h err=%b f=%b want 00 1 100",
                     last_rsp.result, last_rsp.err, last_rsp.flags);
        end
        run_single(4'd13, 4'd3, 3'd7, "div");
    endtask

    task automatic test_back_to_back();
        rsp_t obs [2];
        rsp_t e;
        int   t [2];
        int   n = 0;
        int   start;
        rsp_ready = 1'b1;
        start = cyc;
        cmd_a = 4'd15;
        cmd_b = 4'd15;
        cmd_op = 3'd6;
        cmd_valid = 1'b1;
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL b2b_ready0: got %b want 1", cmd_ready);
        end
        exp_q.push_back(ref_model(4'd15, 4'd15, 3'd6));
        tick();
        cmd_a = 4'hC;
        cmd_b = 4'hA;
        cmd_op = 3'd2;
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL b2b_ready1: got %b want 1", cmd_ready);
        end
        exp_q.push_back(ref_model(4'hC, 4'hA, 3'd2));
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 20 && n < 2; i++) begin
            if (rsp_valid === 1'b1) begin
                obs[n] = grab();
                t[n] = cyc - start;
                e = exp_q.pop_front();
                total++;
                if (obs[n] !== e) begin
                    bad++;
                    $display("[TB] FAIL b2b_rsp%0d: got %h want %h", n, obs[n], e);
                end
                n++;
            end
            tick();
        end
        total++;
        if (n != 2) begin
            bad++;
            $display("[TB] FAIL b2b_count: got %0d want 2", n);
            exp_q.delete();
        end else begin
            total++;
            if (t[0] != 4 || t[1] - t[0] != 3) begin
                bad++;
                $display("[TB] FAIL b2b_timing: got first=%0d gap=%0d want 4 3", t[0], t[1] - t[0]);
            end
            total++;
            if (obs[0].result !== 8'hE1 || obs[1].result !== 8'h08 || obs[1].flags !== 3'b100) begin
                bad++;
                $display("[TB] FAIL b2b_const: got %h %h f=%b want E1 08 100",
                         obs[0].result, obs[1].result, obs[1].flags);
            end
        end
    endtask

    task automatic test_full_fifo();
        int   accepted = 0;
        int   n = 0;
        rsp_t snap;
        rsp_t e;
        rsp_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cmd_a = 4'($urandom);
            cmd_b = 4'($urandom);
            cmd_op = 3'($urandom);
            cmd_valid = 1'b1;
            if (cmd_ready === 1'b1) begin
                exp_q.push_back(ref_model(cmd_a, cmd_b, cmd_op));
                accepted++;
            end
            tick();
        end
        cmd_valid = 1'b0;
        total++;
        if (accepted != DEPTH + 1) begin
            bad++;
            $display("[TB] FAIL full_accepted: got %0d want %0d", accepted, DEPTH + 1);
        end
        total++;
        if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL full_state: got ready=%b valid=%b want 0 1", cmd_ready, rsp_valid);
        end
        snap = grab();
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (rsp_valid !== 1'b1 || grab() !== snap || cmd_ready !== 1'b0) begin
                bad++;
                $display("[TB] FAIL full_stall%0d: got v=%b rsp=%h rdy=%b want 1 %h 0",
                         i, rsp_valid, grab(), cmd_ready, snap);
            end
        end
        rsp_ready = 1'b1;
        for (int i = 0; i < 40 && n < DEPTH + 1; i++) begin
            if (rsp_valid === 1'b1) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 13'h0;
                total++;
                if (grab() !== e) begin
                    bad++;
                    $display("[TB] FAIL full_drain%0d: got %h want %h", n, grab(), e);
                end
                n++;
                tick();
                if (n == 1) begin
                    total++;
                    if (cmd_ready !== 1'b1) begin
                        bad++;
                        $display("[TB] FAIL full_ready_rise: got %b want 1", cmd_ready);
                    end
                end
            end else begin
                tick();
            end
        end
        total++;
        if (n != DEPTH + 1 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL full_drain_done: got n=%0d busy=%b want %0d 0", n, busy, DEPTH + 1);
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        int stray = 0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cmd_a = 4'd2 + 4'(i);
            cmd_b = 4'd1;
            cmd_op = 3'd0;
            cmd_valid = 1'b1;
            total++;
            if (cmd_ready !== 1'b1) begin
                bad++;
                $display("[TB] FAIL rmid_push%0d: got %b want 1", i, cmd_ready);
            end
            tick();
        end
        cmd_valid = 1'b0;
        total++;
        if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rmid_pre: got busy=%b valid=%b want 1 0", busy, rsp_valid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rmid_post: got v=%b rdy=%b busy=%b want 0 1 0",
                     rsp_valid, cmd_ready, busy);
        end
        for (int i = 0; i < 15; i++) begin
            tick();
            if (rsp_valid !== 1'b0 || busy !== 1'b0) stray++;
        end
        total++;
        if (stray != 0) begin
            bad++;
            $display("[TB] FAIL rmid_quiet: got %0d active cycles want 0", stray);
        end
        exp_q.delete();
    endtask

    task automatic test_random();
        int   sent = 0;
        int   got = 0;
        int   cycles = 0;
        bit   stalled = 0;
        rsp_t held;
        rsp_t e;
        while (got < 40 && cycles < 3000) begin
            if (sent < 40 && $urandom_range(0, 3) != 0) begin
                cmd_a = 4'($urandom);
                cmd_op = 3'($urandom);
                cmd_b = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
                cmd_valid = 1'b1;
            end else begin
                cmd_valid = 1'b0;
            end
            rsp_ready = ($urandom_range(0, 2) != 0);
            if (stalled) begin
                total++;
                if (rsp_valid !== 1'b1 || grab() !== held) begin
                    bad++;
                    $display("[TB] FAIL rand_hold: got v=%b %h want 1 %h", rsp_valid, grab(), held);
                end
            end
            if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
                exp_q.push_back(ref_model(cmd_a, cmd_b, cmd_op));
                sent++;
            end
            if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL rand_unexpected: got %h want none", grab());
                end else begin
                    e = exp_q.pop_front();
                    if (grab() !== e) begin
                        bad++;
                        $display("[TB] FAIL rand_rsp%0d: got %h want %h", got, grab(), e);
                    end
                end
                got++;
            end
            stalled = (rsp_valid === 1'b1) && (rsp_ready !== 1'b1);
            held = grab();
            tick();
            cycles++;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        total++;
        if (got != 40) begin
            bad++;
            $display("[TB] FAIL rand_count: got %0d want 40", got);
        end
        exp_q.delete();
    endtask

`ifdef ALU_SEQ_STATS_EN
    task automatic test_stats();
        test_reset();
        total++;
        if (rsp_count !== 16'd0 || err_count !== 8'd0) begin
            bad++;
            $display("[TB] FAIL stats_reset: got %0d %0d want 0 0", rsp_count, err_count);
        end
        run_single(4'd7, 4'd0, 3'd7, "st_div0");
        run_single(4'd9, 4'd8, 3'd0, "st_add");
        run_single(4'd15, 4'd15, 3'd6, "st_mul");
        total++;
        if (rsp_count !== 16'd3 || err_count !== 8'd1) begin
            bad++;
            $display("[TB] FAIL stats_count: got %0d %0d want 3 1", rsp_count, err_count);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        cmd_a = '0;
        cmd_b = '0;
        cmd_op = '0;
        $display("[TB] starting alu_op_sequencer bench");
        test_reset();
        test_add();
        test_div_zero();
        test_back_to_back();
        test_full_fifo();
        test_reset_mid();
        test_random();
`ifdef ALU_SEQ_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Command front-end that feeds the ALU and collects its results.
- Accepts operand/opcode commands over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Issues one command at a time on the ALU's a/b/select inputs, holds them stable across the ALU's one-cycle registered latency, then captures out/carry/compare flags into a response register with valid/ready backpressure.
- Screens divide-by-zero so downstream never consumes an undefined quotient.

Parameters:
- WIDTH, 4, operand width; must match the ALU WIDTH. ALU result is WIDTH*2 bits.
- DEPTH, 4, command FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO not full.
- cmd_a  in  WIDTH  operand a.
- cmd_b  in  WIDTH  operand b.
- cmd_op  in  3  ALU select: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 eq, 110 mul, 111 div.
- alu_a  out  WIDTH  registered operand a to ALU.
- alu_b  out  WIDTH  registered operand b to ALU.
- alu_select  out  3  registered opcode to ALU.
- alu_out  in  WIDTH*2  ALU registered result.
- alu_carry_out  in  1  ALU adder carry.
- alu_a_greater  in  1  ALU compare flag.
- alu_a_equal  in  1  ALU compare flag.
- alu_a_less  in  1  ALU compare flag.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_result  out  WIDTH*2  captured result.
- rsp_flags  out  3  captured {gt, eq, lt}.
- rsp_carry  out  1  captured carry.
- rsp_err  out  1  divide-by-zero.
- busy  out  1  FSM not IDLE or FIFO not empty.

Behaviour:
- Reset, synchronous and active-high:
  - FIFO emptied; FSM returns to IDLE.
  - alu_a, alu_b, alu_select, rsp_result, rsp_flags, rsp_carry, rsp_err, rsp_valid all cleared to 0.
  - cmd_ready=1 and busy=0 in the cycle after reset.
  - Reset mid-operation discards the in-flight command and all queued commands; no response is emitted for them.
- FIFO:
  - Push when cmd_valid & cmd_ready.
  - cmd_ready = !full. No pass-through when full, even if a pop occurs in the same cycle.
  - Simultaneous push and pop while not full leaves the count unchanged.
  - Pointers wrap modulo DEPTH; order is preserved.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if the FIFO is not empty, pop the head, load alu_a/alu_b/alu_select, and go to ISSUE.
  - ISSUE: ALU inputs are stable; the ALU registers out at the end of this cycle. Go to WAIT.
  - WAIT: capture alu_out, alu_carry_out and the three compare flags into the rsp registers, set rsp_valid, go to RESP. ALU inputs are still held, so the combinational flags are valid.
  - RESP: hold rsp_* stable while rsp_valid & !rsp_ready. On handshake, clear rsp_valid. If the FIFO is not empty, pop in the same edge and go to ISSUE; otherwise go to IDLE.
  - alu_a, alu_b and alu_select change only on a pop.
- Latency and throughput:
  - Command accepted in cycle 0 into an empty, idle block gives rsp_valid=1 in cycle 4.
  - Sustained throughput with rsp_ready=1 is one response per 3 cycles.
- Divide-by-zero: when alu_select==111 and alu_b==0, the WAIT capture forces rsp_result=0 and rsp_err=1. Flags and carry are still captured. Otherwise rsp_err=0.
- Width rules: rsp_result takes all WIDTH*2 alu_out bits verbatim; there is no sign or truncation processing.
- Backpressure capacity: with rsp_ready held low, DEPTH+1 commands are accepted in total (DEPTH queued, one in flight).

Optional Feature:
- Macro ALU_SEQ_STATS_EN. When defined, the block adds two outputs:
  - rsp_count, 16 bits: completed response handshakes, saturating at 0xFFFF.
  - err_count, 8 bits: handshakes with rsp_err=1, saturating at 0xFF.
- Both counters reset to 0.
- When the macro is undefined, these ports and their logic are absent.

Test Plan (WIDTH=4, DEPTH=4):
- Add, a=9, b=8, op=000, rsp_ready=1: rsp_valid in cycle 4; rsp_result=0x11, rsp_carry=1, rsp_flags=100.
- Divide by zero, a=7, b=0, op=111: rsp_result=0x00, rsp_err=1, rsp_flags=100.
- Back-to-back with rsp_ready=1:
  - mul, a=15, b=15 gives 0xE1.
  - and, a=0xC, b=0xA gives 0x08 with rsp_flags=100.
  - The two rsp_valid pulses are 3 cycles apart; results arrive in order.
- Full FIFO: push continuously with rsp_ready=0. Exactly 5 commands are accepted and cmd_ready=0 afterwards. rsp_* stays stable for 10 stall cycles. Raising rsp_ready drains 5 responses in order, and cmd_ready rises after the first drain.
- Reset mid-operation: rst=1 for one cycle while in WAIT with 2 queued commands. Next cycle shows rsp_valid=0, cmd_ready=1, busy=0, and no further responses.
- With ALU_SEQ_STATS_EN: the divide-by-zero, add and mul sequence gives rsp_count=3 and err_count=1.
